hex_display_driver: RTL and testbench

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

---
 rtl/hex_display_driver.sv | 107 ++++++++++
 tb/tb_hex_display_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Eight-digit multiplexed hex display driver with a one-entry input buffer.
// A prescaler paces the digit scan; a new value taken from the producer is
// held in the pending buffer and swapped into the display register only at
// a frame boundary, so a frame is never drawn with a mix of old and new digits.
module hex_display_driver #(
    parameter int DIV      = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   disp;
    logic [31:0]   pend;
    logic          pend_full;
    logic          tick;
    logic          wrap;
    logic          hs;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_raw;

    assign tick = (cnt == CW'(DIV - 1));
    assign wrap = tick && (idx == 3'd7);
    assign hs   = in_valid && in_ready;

    // Prescaler and digit index: idx advances once per DIV clocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending buffer and display register. A commit and a handshake can
    // never coincide: a handshake needs an empty buffer, a commit a full one.
    // in_ready is kept as its own register mirroring ~pend_full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            in_ready  <= 1'b1;
        end else if (wrap && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
            in_ready  <= 1'b1;
        end else if (hs) begin
            pend      <= in_data;
            pend_full <= 1'b1;
            in_ready  <= 1'b0;
        end
    end

    // Frame boundary pulse, one cycle after every wrap edge.
    always_ff @(posedge clk) begin
        if (!rst) frame_done <= 1'b0;
        else      frame_done <= wrap;
    end

    // Digit select and glyph decode; blank when this and all higher nibbles
    // are zero, except for digit 0 so a zero value still shows "0".
    always_comb begin
        upper = disp >> {idx, 2'b00};
        nib   = upper[3:0];
        blank = (BLANK_LZ != 0) && (idx != 3'd0) && (upper == 32'd0);
        case (nib)
            4'h0: seg_raw = 7'h40;
            4'h1: seg_raw = 7'h79;
            4'h2: seg_raw = 7'h24;
            4'h3: seg_raw = 7'h30;
            4'h4: seg_raw = 7'h19;
            4'h5: seg_raw = 7'h12;
            4'h6: seg_raw = 7'h02;
            4'h7: seg_raw = 7'h78;
            4'h8: seg_raw = 7'h00;
            4'h9: seg_raw = 7'h10;
            4'hA: seg_raw = 7'h08;
            4'hB: seg_raw = 7'h03;
            4'hC: seg_raw = 7'h46;
            4'hD: seg_raw = 7'h21;
            4'hE: seg_raw = 7'h06;
            default: seg_raw = 7'h0E;
        endcase
        SEG = blank ? 7'h7F : seg_raw;
        AN  = ~(8'b1 << idx);
        DP  = 1'b1;
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: directed table vectors, multi-cycle corner
// sequences, and a random phase checked every cycle against a time-based
// model (digit = elapsed cycles / DIV, frame = 8*DIV cycles).
module tb_hex_display_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;
    localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        rdy1, rdy2, dp1, dp2, fd1, fd2;
    logic [7:0]  an1, an2;
    logic [6:0]  seg1, seg2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hex_display_driver #(.DIV(DIV), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .AN(an1), .SEG(seg1), .DP(dp1), .frame_done(fd1));

    hex_display_driver #(.DIV(DIV), .BLANK_LZ(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
        .AN(an2), .SEG(seg2), .DP(dp2), .frame_done(fd2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_n = 0;
    logic [31:0] m_disp = '0;
    logic [31:0] m_pend = '0;
    logic        m_full = 1'b0;

    function automatic logic [6:0] exp_seg(input logic [31:0] d, input int i, input bit blank_lz);
        logic [31:0] rest;
        rest = d >> (4 * i);
        if (blank_lz && i != 0 && rest == 0) return 7'h7F;
        return SEGTAB[rest % 16];
    endfunction

    // Model: count post-reset edges; an edge closing a multiple of FRAME is a wrap.
    always @(posedge clk) begin
        if (!rst) begin
            m_n <= 0; m_disp <= '0; m_pend <= '0; m_full <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            if (((m_n + 1) % FRAME == 0) && m_full) begin
                m_disp <= m_pend; m_full <= 1'b0;
            end else if (in_valid && !m_full) begin
                m_pend <= in_data; m_full <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int i;
        i = (m_n / DIV) % 8;
        chk("mdl_an",   an1,  32'hFF & ~(32'd1 << i));
        chk("mdl_an2",  an2,  32'hFF & ~(32'd1 << i));
        chk("mdl_seg",  seg1, exp_seg(m_disp, i, 1'b1));
        chk("mdl_seg2", seg2, exp_seg(m_disp, i, 1'b0));
        chk("mdl_rdy",  rdy1, !m_full);
        chk("mdl_fd",   fd1,  (m_n > 0) && (m_n % FRAME == 0));
        chk("mdl_dp",   {dp1, dp2}, 2'b11);
    end

    // ---------------- helpers ----------------
    task automatic wait_frame(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!fd1 && cyc < 200);
        chk("frame_timeout", fd1, 1'b1);
    endtask

    task automatic send(input logic [31:0] v);
        int k;
        k = 0;
        while (!rdy1 && k < 400) begin @(negedge clk); k++; end
        chk("ready_timeout", rdy1, 1'b1);
        in_valid = 1'b1; in_data = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0]     data;
        logic [7:0][6:0] seg;
        logic [7:0][6:0] seg_nb;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  an_tab[8];
    logic [31:0] v;
    int          cyc;

    initial begin
        an_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        vecs[0] = '{32'h00000007, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h78},
                                  {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h78}};
        vecs[1] = '{32'hDEADBEEF, {7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E},
                                  {7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E}};
        vecs[2] = '{32'h00000100, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40,7'h40},
                                  {7'h40,7'h40,7'h40,7'h40,7'h40,7'h79,7'h40,7'h40}};
        vecs[3] = '{32'h10000000, {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40},
                                  {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};
        vecs[4] = '{32'h00000000, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40},
                                  {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};
        vecs[5] = '{32'h0A0C0000, {7'h7F,7'h08,7'h40,7'h46,7'h40,7'h40,7'h40,7'h40},
                                  {7'h40,7'h08,7'h40,7'h46,7'h40,7'h40,7'h40,7'h40}};

        // Reset state and scan timing.
        repeat (3) @(negedge clk);
        chk("rst_an", an1, 8'hFE);
        chk("rst_seg", seg1, 7'h40);
        chk("rst_rdy", rdy1, 1'b1);
        chk("rst_fd", fd1, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("scan_an", an1, an_tab[k]);
            repeat (DIV) @(negedge clk);
        end
        chk("first_fd", fd1, 1'b1);
        wait_frame(cyc);
        chk("frame_period", cyc, FRAME);

        // Table vectors: commit each value, then read every digit.
        for (int t = 0; t < 6; t++) begin
            send(vecs[t].data);
            wait_frame(cyc);
            for (int k = 0; k < 8; k++) begin
                chk("vec_an", an1, an_tab[k]);
                chk("vec_seg", seg1, vecs[t].seg[k]);
                chk("vec_seg_nb", seg2, vecs[t].seg_nb[k]);
                if (k < 7) repeat (DIV) @(negedge clk);
            end
            chk("vec_rdy", rdy1, 1'b1);
        end

        // Second offer while the buffer is full is dropped.
        wait_frame(cyc);
        send(32'hDEADBEEF);
        chk("drop_rdy_low", rdy1, 1'b0);
        in_valid = 1'b1; in_data = 32'h12345678;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_frame(cyc);
        chk("drop_rdy_back", rdy1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("drop_seg", seg1, vecs[1].seg[k]);
            if (k < 7) repeat (DIV) @(negedge clk);
        end
        wait_frame(cyc);
        chk("drop_still", seg1, 7'h0E);

        // Handshake exactly on the wrap edge: old value stays for one frame.
        repeat (FRAME - 1) @(negedge clk);
        chk("wrapedge_rdy", rdy1, 1'b1);
        in_valid = 1'b1; in_data = 32'h00000007;
        @(negedge clk);
        in_valid = 1'b0;
        chk("wrapedge_fd", fd1, 1'b1);
        chk("wrapedge_old", seg1, 7'h0E);
        chk("wrapedge_pend", rdy1, 1'b0);
        wait_frame(cyc);
        chk("wrapedge_new", seg1, 7'h78);
        chk("wrapedge_gap", cyc, FRAME);

        // Reset mid-frame with a value pending: nothing commits.
        wait_frame(cyc);
        repeat (5) @(negedge clk);
        send(32'h00000009);
        chk("rstmid_pend", rdy1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_an", an1, 8'hFE);
        chk("rstmid_seg", seg1, 7'h40);
        chk("rstmid_rdy", rdy1, 1'b1);
        rst = 1'b1;
        wait_frame(cyc);
        chk("rstmid_period", cyc, FRAME);
        chk("rstmid_nocommit", seg1, 7'h40);
        repeat (DIV) @(negedge clk);
        chk("rstmid_blank", seg1, 7'h7F);

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 2500; c++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            v = $urandom;
            in_data = v >> $urandom_range(0, 31);
            rst = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
